adc_voltmeter: RTL and testbench
================================

Name: adc_voltmeter

Overview:
- Converts the raw ADC sample stream into a display-ready millivolt reading.
- Sits between the ADC SPI interface (its data/valid outputs) and the 7-segment decoders.
- Supersedes the fixed "×33/10 then combinational BCD" path with:
  - a parametrised reference voltage and sample width;
  - N-sample block averaging;
  - an iterative (sequential) binary-to-BCD converter;
  - display hold and overrun reporting.

Parameters:
- DATA_W, 10: ADC sample width in bits.
- AVG_LOG2, 2: log2 of the number of samples averaged per reading (0 = no averaging).
- VREF_MV, 3300: full-scale reference in millivolts. Must be ≤ 9999.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous, active-high reset.
- sample  in  DATA_W  raw ADC code.
- sample_valid  in  1  one-cycle strobe; sample is accepted on any cycle it is high.
- hold  in  1  freezes the displayed result while high.
- mv  out  14  latest reading in millivolts (0..9999).
- bcd0..bcd3  out  4 each  BCD digits of mv; bcd0 = units, bcd3 = thousands.
- result_valid  out  1  one-cycle pulse when mv/bcd update.
- busy  out  1  high while a scale/convert is in progress.
- overrun  out  1  sticky flag: a completed average was discarded.
- peak_mv  out  14  present only with PEAK_HOLD_EN.
- peak_clr  in  1  present only with PEAK_HOLD_EN.

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - mv, bcd0..bcd3, result_valid, busy, overrun, peak_mv = 0.
  - Accumulator, sample counter and pending flag cleared; FSM to IDLE.
  - Applies mid-conversion too; no result_valid is produced for the aborted conversion.
- Accumulator:
  - Width DATA_W+AVG_LOG2. Each accepted sample is added and the counter increments.
  - On the 2^AVG_LOG2-th sample: avg = (acc + sample) >> AVG_LOG2 is registered, and acc/counter clear in the same edge.
  - Accumulation never stalls, regardless of FSM state.
- Scaling:
  - mv_next = (avg × VREF_MV) >> DATA_W, truncating.
  - Intermediate width is DATA_W+14; the result always fits 14 bits.
- FSM states:
  - IDLE: busy=0. A new avg moves the FSM to SCALE.
  - SCALE: one cycle; registers mv_next and loads the shift-add-3 register; goes to CONV.
  - CONV: 14 iterations, one bit per clk (add 3 to any BCD nibble ≥5, then shift); goes to DONE.
  - DONE: one cycle.
    - If hold=0: mv and bcd0..3 load, and result_valid pulses in the following cycle.
    - If hold=1: outputs are unchanged and there is no pulse.
    - Then go to SCALE if pending is set (clearing it), else to IDLE.
- Latency: sample_valid completing an average in cycle N gives result_valid high in cycle N+17. Outputs change in the same cycle as the pulse.
- busy is high in SCALE, CONV and DONE.
- A new avg arriving while busy=1:
  - It is stored in a one-deep pending register and pending is set.
  - If pending is already set, it is overwritten (newest wins) and overrun is set.
  - overrun clears only on rst.
- When an avg completes in the same cycle as DONE with pending clear, the new avg becomes pending and is not lost.
- hold has no effect on accumulation, conversion or overrun.

Optional Feature:
- Macro: PEAK_HOLD_EN.
- Defined:
  - peak_mv tracks the maximum mv ever loaded. It updates in the same cycle as mv, only when hold=0.
  - peak_clr (synchronous) sets peak_mv to 0. If a load occurs in the same cycle, the load value wins.
- Undefined: the peak_mv and peak_clr ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Four samples of 512, then idle:
  - result_valid in cycle N+17;
  - mv=1650, bcd3..0 = 1,6,5,0;
  - busy is high for exactly 16 cycles.
- Four samples of 1023: mv=3296, bcd = 3,2,9,6.
- Samples 0,0,0,4: avg=1, mv=3, bcd = 0,0,0,3.
- hold=1 with four samples of 100:
  - no result_valid; previous mv is retained.
  - Release hold, then four samples of 200: mv=644.
- sample_valid high for 12 consecutive cycles of value 300 (averages complete in cycles 3, 7 and 11):
  - overrun=1 after the cycle-11 average;
  - exactly two result_valid pulses, both with mv=966.
- rst asserted at cycle N+8 of a conversion:
  - all outputs are 0 the next cycle;
  - no result_valid follows;
  - a subsequent four samples of 512 gives mv=1650.
- With PEAK_HOLD_EN: readings 1650 then 644 give peak_mv=1650; peak_clr then gives peak_mv=0.

Source files
------------

// File: rtl/adc_voltmeter.sv
// ADC sample stream to averaged millivolt reading with sequential BCD conversion.
// Optional peak-hold tracking is enabled by defining PEAK_HOLD_EN.
module adc_voltmeter #(
  parameter int DATA_W   = 10,
  parameter int AVG_LOG2 = 2,
  parameter int VREF_MV  = 3300
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  input  logic              hold,
`ifdef PEAK_HOLD_EN
  input  logic              peak_clr,
  output logic [13:0]       peak_mv,
`endif
  output logic [13:0]       mv,
  output logic [3:0]        bcd0,
  output logic [3:0]        bcd1,
  output logic [3:0]        bcd2,
  output logic [3:0]        bcd3,
  output logic              result_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int ACC_W    = DATA_W + AVG_LOG2;
  localparam int CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int CNT_LAST = (1 << AVG_LOG2) - 1;
  localparam int PROD_W   = DATA_W + 14;

  typedef enum logic [1:0] {IDLE, SCALE, CONV, DONE} state_t;

  state_t              state, state_d;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    sum;
  logic [CNT_W-1:0]    cnt;
  logic                avg_done;
  logic [DATA_W-1:0]   avg_new;
  logic [DATA_W-1:0]   avg_q;
  logic [DATA_W-1:0]   pend_q;
  logic                pending;
  logic                free_slot;
  logic [PROD_W-1:0]   prod;
  logic [13:0]         mv_next;
  logic [13:0]         mv_calc;
  logic [29:0]         shreg;
  logic [3:0]          iter;
  logic                load;

  // One double-dabble iteration: correct every BCD nibble, then shift left.
  function automatic logic [29:0] dabble_step(input logic [29:0] s);
    logic [29:0] t;
    t = s;
    for (int i = 0; i < 4; i++) begin
      if (t[14+4*i +: 4] >= 4'd5) t[14+4*i +: 4] = t[14+4*i +: 4] + 4'd3;
    end
    return {t[28:0], 1'b0};
  endfunction

  assign sum      = acc + ACC_W'(sample);
  assign avg_done = sample_valid && (cnt == CNT_W'(CNT_LAST));
  assign avg_new  = DATA_W'(sum >> AVG_LOG2);
  assign prod     = PROD_W'(avg_q) * PROD_W'(VREF_MV);
  assign mv_next  = 14'(prod >> DATA_W);

  always_comb begin
    state_d   = state;
    busy      = (state != IDLE);
    load      = (state == DONE) && !hold;
    free_slot = (state == IDLE) || (state == DONE);
    case (state)
      IDLE:    if (pending || avg_done) state_d = SCALE;
      SCALE:   state_d = CONV;
      CONV:    if (iter == 4'd13) state_d = DONE;
      DONE:    state_d = pending ? SCALE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Accumulation runs independently of the converter so it never stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (sample_valid) begin
      if (avg_done) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // A pending average is consumed whenever the converter can start a new job;
  // a completed average that cannot start immediately lands in the pending slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      avg_q   <= '0;
      pend_q  <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else if (free_slot && pending) begin
      avg_q <= pend_q;
      if (avg_done) pend_q  <= avg_new;
      else          pending <= 1'b0;
    end else if (avg_done) begin
      if (state == IDLE) begin
        avg_q <= avg_new;
      end else begin
        pend_q  <= avg_new;
        pending <= 1'b1;
        if (pending) overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mv_calc <= '0;
      shreg   <= '0;
      iter    <= '0;
    end else if (state == SCALE) begin
      mv_calc <= mv_next;
      shreg   <= {16'd0, mv_next};
      iter    <= '0;
    end else if (state == CONV) begin
      shreg <= dabble_step(shreg);
      iter  <= iter + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mv           <= '0;
      bcd0         <= '0;
      bcd1         <= '0;
      bcd2         <= '0;
      bcd3         <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= load;
      if (load) begin
        mv   <= mv_calc;
        bcd0 <= shreg[17:14];
        bcd1 <= shreg[21:18];
        bcd2 <= shreg[25:22];
        bcd3 <= shreg[29:26];
      end
    end
  end

`ifdef PEAK_HOLD_EN
  // A load in the same cycle as a clear takes precedence over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_mv <= '0;
    end else if (load) begin
      if (peak_clr || (mv_calc > peak_mv)) peak_mv <= mv_calc;
    end else if (peak_clr) begin
      peak_mv <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_adc_voltmeter.sv
// Directed bench for adc_voltmeter: expected readings queued at stimulus time,
// compared against each result_valid pulse.
module tb_adc_voltmeter;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  sample;
  logic        sample_valid;
  logic        hold;
  logic [13:0] mv;
  logic [3:0]  bcd0, bcd1, bcd2, bcd3;
  logic        result_valid;
  logic        busy;
  logic        overrun;
`ifdef PEAK_HOLD_EN
  logic        peak_clr;
  logic [13:0] peak_mv;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;
  int last_pulse_cyc = 0;
  int busy_cnt = 0;
  int last_cyc = 0;
  logic [13:0] exp_q[$];

  adc_voltmeter dut (
    .clk          (clk),
    .rst          (rst),
    .sample       (sample),
    .sample_valid (sample_valid),
    .hold         (hold),
`ifdef PEAK_HOLD_EN
    .peak_clr     (peak_clr),
    .peak_mv      (peak_mv),
`endif
    .mv           (mv),
    .bcd0         (bcd0),
    .bcd1         (bcd1),
    .bcd2         (bcd2),
    .bcd3         (bcd3),
    .result_valid (result_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  // clock / cycle counter
  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [13:0] exp_mv(input int avg);
    return 14'((avg * 3300) >> 10);
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int v);
    sample       = 10'(v);
    sample_valid = 1'b1;
    last_cyc     = cyc;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic send4(input int v);
    for (int i = 0; i < 4; i++) send(v);
  endtask

  task automatic wait_pulse(input int target);
    int n;
    n = 0;
    while (pulses < target && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("pulse_timeout", 32'(pulses >= target), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // scoreboard: pop one expected reading per result_valid pulse
  always @(negedge clk) begin
    logic [13:0] e;
    if (busy) busy_cnt++;
    if (!rst && result_valid) begin
      pulses++;
      last_pulse_cyc = cyc;
      check("pulse_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_mv", 32'(mv), 32'(e));
        check("sb_bcd", 32'({bcd3, bcd2, bcd1, bcd0}), 32'(to_bcd(int'(e))));
      end
    end
  end

  initial begin
    int p;
    int n;
    rst = 1'b1; hold = 1'b0; sample = '0; sample_valid = 1'b0;
`ifdef PEAK_HOLD_EN
    peak_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    check("rst_mv", 32'(mv), 0);
    check("rst_bcd", 32'({bcd3, bcd2, bcd1, bcd0}), 0);
    check("rst_rv", 32'(result_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(overrun), 0);
`ifdef PEAK_HOLD_EN
    check("rst_peak", 32'(peak_mv), 0);
`endif

    // four samples of 512: latency, busy width, digits
    busy_cnt = 0;
    p = pulses;
    exp_q.push_back(exp_mv(512));
    send4(512);
    n = last_cyc;
    wait_pulse(p + 1);
    check("latency", 32'(last_pulse_cyc), 32'(n + 17));
    check("busy_cycles", 32'(busy_cnt), 16);
    check("mv_512", 32'(mv), 1650);
    check("bcd_512", 32'({bcd3, bcd2, bcd1, bcd0}), 32'h1650);

    // full scale
    p = pulses;
    exp_q.push_back(exp_mv(1023));
    send4(1023);
    wait_pulse(p + 1);
    check("mv_1023", 32'(mv), 3296);
    check("bcd_1023", 32'({bcd3, bcd2, bcd1, bcd0}), 32'h3296);

    // 0,0,0,4 -> avg 1
    p = pulses;
    exp_q.push_back(exp_mv(1));
    send(0); send(0); send(0); send(4);
    wait_pulse(p + 1);
    check("mv_avg1", 32'(mv), 3);
    check("bcd_avg1", 32'({bcd3, bcd2, bcd1, bcd0}), 32'h0003);

    // hold suppresses the update and the pulse
    p = pulses;
    hold = 1'b1;
    send4(100);
    repeat (25) @(posedge clk);
    #1;
    check("hold_no_pulse", 32'(pulses), 32'(p));
    check("hold_mv_kept", 32'(mv), 3);
    hold = 1'b0;
    exp_q.push_back(exp_mv(200));
    send4(200);
    wait_pulse(p + 1);
    check("mv_200", 32'(mv), 644);

    // back-to-back averages: one pending, then one overwritten
    check("overrun_pre", 32'(overrun), 0);
    p = pulses;
    exp_q.push_back(exp_mv(300));
    exp_q.push_back(exp_mv(300));
    for (int i = 0; i < 8; i++) send(300);
    check("overrun_one_pending", 32'(overrun), 0);
    for (int i = 0; i < 4; i++) send(300);
    check("overrun_set", 32'(overrun), 1);
    wait_pulse(p + 2);
    repeat (30) @(posedge clk);
    #1;
    check("overrun_pulses", 32'(pulses), 32'(p + 2));
    check("mv_300", 32'(mv), 966);
    check("overrun_sticky", 32'(overrun), 1);

    // reset in the middle of a conversion
    p = pulses;
    send4(512);
    n = last_cyc;
    while (cyc < n + 8) begin
      @(posedge clk); #1;
    end
    check("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_mv", 32'(mv), 0);
    check("abort_bcd", 32'({bcd3, bcd2, bcd1, bcd0}), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_rv", 32'(result_valid), 0);
    check("abort_overrun", 32'(overrun), 0);
    repeat (30) @(posedge clk);
    #1;
    check("abort_no_pulse", 32'(pulses), 32'(p));
    exp_q.push_back(exp_mv(512));
    send4(512);
    wait_pulse(p + 1);
    check("mv_after_abort", 32'(mv), 1650);

`ifdef PEAK_HOLD_EN
    check("peak_1650", 32'(peak_mv), 1650);
    p = pulses;
    exp_q.push_back(exp_mv(200));
    send4(200);
    wait_pulse(p + 1);
    check("peak_kept", 32'(peak_mv), 1650);
    peak_clr = 1'b1;
    @(posedge clk); #1;
    peak_clr = 1'b0;
    check("peak_clr", 32'(peak_mv), 0);
`endif

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
